dcache_ctrl: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_array.sv | 46 ++++
 rtl/dcache_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the MEM-stage data cache.
package dcache_pkg;

  localparam int unsigned DcacheAddrW     = 16;
  localparam int unsigned DcacheDataW     = 16;
  localparam int unsigned DcacheIndexBits = 4;

  // Tag width is whatever address remains above the line index.
  function automatic int unsigned tagWidth(input int unsigned addrW, input int unsigned indexBits);
    return addrW - indexBits;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StWthru,
    StDone
  } dcache_state_e;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid/tag/data per one-word line.
// Combinational read port, single synchronous write port, valid bits cleared on rst.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_W     = DcacheDataW,
  parameter int unsigned INDEX_BITS = DcacheIndexBits,
  parameter int unsigned TAG_W      = tagWidth(DcacheAddrW, DcacheIndexBits)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] rdIndex_i,
  output logic                  rdValid_o,
  output logic [TAG_W-1:0]      rdTag_o,
  output logic [DATA_W-1:0]     rdData_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wrIndex_i,
  input  logic [TAG_W-1:0]      wrTag_i,
  input  logic [DATA_W-1:0]     wrData_i
);

  localparam int unsigned NumLines = 1 << INDEX_BITS;

  logic [NumLines-1:0] validQ;
  logic [TAG_W-1:0]    tagQ  [NumLines];
  logic [DATA_W-1:0]   dataQ [NumLines];

  // Line write; reset only invalidates, tag/data contents are don't-care until refilled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      validQ <= '0;
    end else if (we_i) begin
      validQ[wrIndex_i] <= 1'b1;
      tagQ[wrIndex_i]   <= wrTag_i;
      dataQ[wrIndex_i]  <= wrData_i;
    end
  end

  // Lookup port.
  always_comb begin
    rdValid_o = validQ[rdIndex_i];
    rdTag_o   = tagQ[rdIndex_i];
    rdData_o  = dataQ[rdIndex_i];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-through, no-write-allocate direct-mapped D-cache controller for the MEM stage.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W     = DcacheAddrW,
  parameter int unsigned DATA_W     = DcacheDataW,
  parameter int unsigned INDEX_BITS = DcacheIndexBits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              hit,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memReady
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       hitCount,
  output logic [15:0]       missCount
`endif
);

  localparam int unsigned TAG_W = tagWidth(ADDR_W, INDEX_BITS);

  dcache_state_e stateQ, stateD;

  logic              memReqQ, memReqD;
  logic              memWeQ, memWeD;
  logic [ADDR_W-1:0] memAddrQ, memAddrD;
  logic [DATA_W-1:0] memWDataQ, memWDataD;

  logic [INDEX_BITS-1:0] lkIndex;
  logic [TAG_W-1:0]      lkTag;
  logic                  lineValid;
  logic [TAG_W-1:0]      lineTag;
  logic [DATA_W-1:0]     lineData;
  logic                  lookupHit;

  logic                  arrWe;
  logic [INDEX_BITS-1:0] arrIndex;
  logic [TAG_W-1:0]      arrTag;
  logic [DATA_W-1:0]     arrData;

  assign lkIndex   = addr[INDEX_BITS-1:0];
  assign lkTag     = addr[ADDR_W-1:INDEX_BITS];
  assign lookupHit = lineValid && (lineTag == lkTag);

  dcache_array #(
    .DATA_W     (DATA_W),
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) uArray (
    .clk_i     (clk),
    .rst_i     (rst),
    .rdIndex_i (lkIndex),
    .rdValid_o (lineValid),
    .rdTag_o   (lineTag),
    .rdData_o  (lineData),
    .we_i      (arrWe),
    .wrIndex_i (arrIndex),
    .wrTag_i   (arrTag),
    .wrData_i  (arrData)
  );

  // State and memory-request registers; reset aborts any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StIdle;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWDataQ <= '0;
    end else begin
      stateQ    <= stateD;
      memReqQ   <= memReqD;
      memWeQ    <= memWeD;
      memAddrQ  <= memAddrD;
      memWDataQ <= memWDataD;
    end
  end

  // Next state, stall qualifier, request launch and array write selection.
  always_comb begin
    stateD    = stateQ;
    hit       = 1'b0;
    memReqD   = memReqQ;
    memWeD    = memWeQ;
    memAddrD  = memAddrQ;
    memWDataD = memWDataQ;
    arrWe     = 1'b0;
    arrIndex  = lkIndex;
    arrTag    = lkTag;
    arrData   = writeData;

    unique case (stateQ)
      StIdle: begin
        hit = 1'b1;
        if (memWrite) begin
          // Every store goes through to memory; a hit also updates the line now.
          hit       = 1'b0;
          stateD    = StWthru;
          memReqD   = 1'b1;
          memWeD    = 1'b1;
          memAddrD  = addr;
          memWDataD = writeData;
          arrWe     = lookupHit;
        end else if (memRead && !lookupHit) begin
          hit      = 1'b0;
          stateD   = StRefill;
          memReqD  = 1'b1;
          memWeD   = 1'b0;
          memAddrD = addr;
        end
      end
      StRefill: begin
        if (memReady) begin
          // Fill from the registered request address, not the live pipeline address.
          arrWe    = 1'b1;
          arrIndex = memAddrQ[INDEX_BITS-1:0];
          arrTag   = memAddrQ[ADDR_W-1:INDEX_BITS];
          arrData  = memRData;
          memReqD  = 1'b0;
          stateD   = StDone;
        end
      end
      StWthru: begin
        if (memReady) begin
          memReqD = 1'b0;
          stateD  = StDone;
        end
      end
      StDone: begin
        hit    = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // Load data is only driven when the addressed line is present; zero otherwise.
  always_comb begin
    readData = '0;
    if (lookupHit && (stateQ == StIdle || stateQ == StDone)) begin
      readData = lineData;
    end
  end

  assign memReq   = memReqQ;
  assign memWe    = memWeQ;
  assign memAddr  = memAddrQ;
  assign memWData = memWDataQ;

`ifdef DCACHE_STATS_EN
  logic readHitEv;
  logic readMissEv;

  assign readHitEv  = (stateQ == StIdle) && memRead && !memWrite && lookupHit;
  assign readMissEv = (stateQ == StIdle) && memRead && !memWrite && !lookupHit;

  // Saturating load hit/miss counters; stores are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (readHitEv && hitCount != 16'hFFFF) begin
        hitCount <= hitCount + 16'd1;
      end
      if (readMissEv && missCount != 16'hFFFF) begin
        missCount <= missCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl (stats checks when DCACHE_STATS_EN is defined).
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [15:0] addr;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic        hit;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic [15:0] memRData;
  logic        memReady;
`ifdef DCACHE_STATS_EN
  logic [15:0] hitCount;
  logic [15:0] missCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData),
    .hit       (hit),
    .memReq    (memReq),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memWData  (memWData),
    .memRData  (memRData),
    .memReady  (memReady)
`ifdef DCACHE_STATS_EN
    ,
    .hitCount  (hitCount),
    .missCount (missCount)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: wait some cycles, then a one-cycle ready pulse with read data.
  task automatic memRespond(input logic [15:0] d, input int waitCyc);
    repeat (waitCyc) step();
    memRData = d;
    memReady = 1'b1;
    step();
    memReady = 1'b0;
    memRData = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; addr = '0; writeData = '0;
    memRData = '0; memReady = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit: got %b want 1", hit); end
    checks++; if (readData !== 16'h0000) begin errors++; $display("FAIL reset_readData: got %h want 0000", readData); end
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq: got %b want 0", memReq); end
    checks++; if (memWe !== 1'b0) begin errors++; $display("FAIL reset_memWe: got %b want 0", memWe); end
    checks++; if (memAddr !== 16'h0000) begin errors++; $display("FAIL reset_memAddr: got %h want 0000", memAddr); end
    checks++; if (memWData !== 16'h0000) begin errors++; $display("FAIL reset_memWData: got %h want 0000", memWData); end
  endtask

  task automatic test_read_miss_refill();
    memRead = 1'b1; addr = 16'h0012;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit_comb: got %b want 0", hit); end
    step();
    checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL miss_memReq: got %b want 1", memReq); end
    checks++; if (memWe !== 1'b0) begin errors++; $display("FAIL miss_memWe: got %b want 0", memWe); end
    checks++; if (memAddr !== 16'h0012) begin errors++; $display("FAIL miss_memAddr: got %h want 0012", memAddr); end
    step(); step();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL refill_stall: got %b want 0", hit); end
    checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL refill_req_held: got %b want 1", memReq); end
    memRespond(16'hBEEF, 0);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL done_hit: got %b want 1", hit); end
    checks++; if (readData !== 16'hBEEF) begin errors++; $display("FAIL done_readData: got %h want beef", readData); end
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL done_memReq: got %b want 0", memReq); end
    memRead = 1'b0;
    step();
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL idle_after_done: got %b want 1", hit); end
  endtask

  task automatic test_read_hit();
    memRead = 1'b1; addr = 16'h0012;
    #1;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rehit_hit: got %b want 1", hit); end
    checks++; if (readData !== 16'hBEEF) begin errors++; $display("FAIL rehit_readData: got %h want beef", readData); end
    step();
    memRead = 1'b0;
    #1;
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL rehit_memReq: got %b want 0", memReq); end
  endtask

  task automatic test_conflict_miss();
    memRead = 1'b1; addr = 16'h0102;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL conflict_hit: got %b want 0", hit); end
    step();
    checks++; if (memAddr !== 16'h0102) begin errors++; $display("FAIL conflict_memAddr: got %h want 0102", memAddr); end
    memRespond(16'h1234, 1);
    checks++; if (readData !== 16'h1234) begin errors++; $display("FAIL conflict_readData: got %h want 1234", readData); end
    memRead = 1'b0;
    step();
    memRead = 1'b1; addr = 16'h0012;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL evicted_hit: got %b want 0", hit); end
    step();
    memRespond(16'hBEEF, 0);
    memRead = 1'b0;
    step();
`ifdef DCACHE_STATS_EN
    checks++; if (hitCount !== 16'd1) begin errors++; $display("FAIL stats_hitCount: got %0d want 1", hitCount); end
    checks++; if (missCount !== 16'd3) begin errors++; $display("FAIL stats_missCount: got %0d want 3", missCount); end
`endif
  endtask

  task automatic test_write_through();
    // Bring 0x0102 back into index 2 so the store is a write hit.
    memRead = 1'b1; addr = 16'h0102;
    step();
    memRespond(16'h1234, 0);
    memRead = 1'b0;
    step();
    memWrite = 1'b1; addr = 16'h0102; writeData = 16'h5555;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL wr_hit_comb: got %b want 0", hit); end
    step();
    checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL wr_memReq: got %b want 1", memReq); end
    checks++; if (memWe !== 1'b1) begin errors++; $display("FAIL wr_memWe: got %b want 1", memWe); end
    checks++; if (memAddr !== 16'h0102) begin errors++; $display("FAIL wr_memAddr: got %h want 0102", memAddr); end
    checks++; if (memWData !== 16'h5555) begin errors++; $display("FAIL wr_memWData: got %h want 5555", memWData); end
    step();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL wr_stall: got %b want 0", hit); end
    memRespond(16'hDEAD, 0);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL wr_done_hit: got %b want 1", hit); end
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL wr_done_memReq: got %b want 0", memReq); end
    memWrite = 1'b0;
    step();
    memRead = 1'b1; addr = 16'h0102;
    #1;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL wr_reread_hit: got %b want 1", hit); end
    checks++; if (readData !== 16'h5555) begin errors++; $display("FAIL wr_reread_data: got %h want 5555", readData); end
    step();
    memRead = 1'b0;
    // Write miss must not allocate.
    memWrite = 1'b1; addr = 16'h0003; writeData = 16'hAAAA;
    step();
    memRespond(16'hDEAD, 1);
    memWrite = 1'b0;
    step();
    memRead = 1'b1; addr = 16'h0003;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL noalloc_hit: got %b want 0", hit); end
    step();
    checks++; if (memWe !== 1'b0) begin errors++; $display("FAIL noalloc_memWe: got %b want 0", memWe); end
    memRespond(16'h4321, 0);
    checks++; if (readData !== 16'h4321) begin errors++; $display("FAIL noalloc_refill: got %h want 4321", readData); end
    memRead = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    memRead = 1'b1; addr = 16'h0045;
    step(); step();
    checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL abort_pre_req: got %b want 1", memReq); end
    rst = 1'b1; memRead = 1'b0;
    step();
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL abort_req_drop: got %b want 0", memReq); end
    rst = 1'b0;
    memRData = 16'h9999; memReady = 1'b1;
    step();
    memReady = 1'b0; memRData = '0;
    #1;
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL late_ready_req: got %b want 0", memReq); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL late_ready_hit: got %b want 1", hit); end
    memRead = 1'b1; addr = 16'h0045;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL abort_no_fill: got %b want 0", hit); end
    addr = 16'h0102;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL abort_prior_miss: got %b want 0", hit); end
    memRead = 1'b0;
    #1;
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats_saturate();
    memRead = 1'b1; addr = 16'h0045;
    step();
    memRespond(16'h7777, 0);
    memRead = 1'b0;
    step();
    memRead = 1'b1;
    repeat (65536) step();
    checks++; if (hitCount !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h want ffff", hitCount); end
    step();
    checks++; if (hitCount !== 16'hFFFF) begin errors++; $display("FAIL stats_sat_hold: got %h want ffff", hitCount); end
    memRead = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_read_miss_refill();
    test_read_hit();
    test_conflict_miss();
    test_write_through();
    test_reset_abort();
`ifdef DCACHE_STATS_EN
    test_stats_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
